// File: rtl/dmem_mmio_responder.sv
// Data-memory slave: word RAM plus UART TX (8-entry FIFO, 8N1) and a 64-bit cycle counter; read data 1 cycle after request.
// Never stalls the requester: a push into a full TX FIFO is dropped and latched in a sticky overflow flag.
module dmem_mmio_responder #(
   parameter int RAM_WORDS = 1024,
   parameter int CLK_DIV   = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmem_en,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_d,
   input  logic [3:0]  dmem_we,
   output logic [31:0] dmem_q,
   output logic        uart_tx
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(CLK_DIV);

   localparam logic [31:0] ADDR_UART_DATA = 32'h8000_0000;
   localparam logic [31:0] ADDR_UART_STAT = 32'h8000_0004;
   localparam logic [31:0] ADDR_CYC_LO    = 32'h8000_0008;
   localparam logic [31:0] ADDR_CYC_HI    = 32'h8000_000C;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   // Request decode
   logic          rd_req;
   logic          wr_req;
   logic          hit_ram;
   logic          hit_data;
   logic          hit_stat;
   logic          hit_lo;
   logic          hit_hi;
   logic [AW-1:0] ram_idx;

   assign rd_req   = dmem_en && (dmem_we == 4'b0000);
   assign wr_req   = dmem_en && (dmem_we != 4'b0000);
   assign hit_ram  = (dmem_addr[31:AW+2] == '0);
   assign hit_data = (dmem_addr == ADDR_UART_DATA);
   assign hit_stat = (dmem_addr == ADDR_UART_STAT);
   assign hit_lo   = (dmem_addr == ADDR_CYC_LO);
   assign hit_hi   = (dmem_addr == ADDR_CYC_HI);
   assign ram_idx  = dmem_addr[AW+1:2];

   // RAM contents survive reset
   logic [31:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (wr_req && hit_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_we[i]) begin
               ram_q[ram_idx][8*i +: 8] <= dmem_d[8*i +: 8];
            end
         end
      end
   end

   // TX FIFO
   logic [7:0] fifo_q [8];
   logic [2:0] wptr_q;
   logic [2:0] rptr_q;
   logic [3:0] cnt_q;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push_req;
   logic       push;
   logic       pop;

   assign fifo_empty = (cnt_q == 4'd0);
   assign fifo_full  = (cnt_q == 4'd8);
   assign push_req   = wr_req && hit_data && dmem_we[0];
   // A full FIFO still accepts when the transmitter frees a slot on the same edge
   assign push       = push_req && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wptr_q] <= dmem_d[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= 3'd0;
         rptr_q <= 3'd0;
         cnt_q  <= 4'd0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 3'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 3'd1;
         end
         cnt_q <= cnt_q + 4'(push) - 4'(pop);
      end
   end

   // Sticky overflow, write-1-to-clear; a new drop wins over a clear
   logic ovf_q;
   logic ovf_set;
   logic ovf_clr;

   assign ovf_set = push_req && !push;
   assign ovf_clr = wr_req && hit_stat && dmem_we[1] && dmem_d[11];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set || (ovf_q && !ovf_clr);
      end
   end

   // Transmitter
   tx_state_t     state_q;
   logic [CW-1:0] div_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          div_end;
   logic          busy;

   assign div_end = (div_q == CW'(CLK_DIV - 1));
   assign busy    = (state_q != S_IDLE);
   assign pop     = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && div_end));
   assign uart_tx = tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               div_q <= '0;
               if (pop) begin
                  shift_q <= fifo_q[rptr_q];
                  state_q <= S_START;
                  tx_q    <= 1'b0;
               end
            end
            S_START: begin
               if (div_end) begin
                  div_q   <= '0;
                  bit_q   <= 3'd0;
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            S_DATA: begin
               if (div_end) begin
                  div_q <= '0;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            S_STOP: begin
               if (div_end) begin
                  div_q <= '0;
                  // Back-to-back frames: next start bit follows the stop bit directly
                  if (pop) begin
                     shift_q <= fifo_q[rptr_q];
                     state_q <= S_START;
                     tx_q    <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  div_q <= div_q + CW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   // Read mux, cycle counter and high-word shadow
   logic [63:0] cyc_q;
   logic [31:0] shadow_q;
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   always_comb begin
      rdata_d = 32'd0;
      if (hit_ram) begin
         rdata_d = ram_q[ram_idx];
      end else if (hit_stat) begin
         rdata_d = {20'd0, ovf_q, busy, fifo_full, fifo_empty, 4'd0, cnt_q};
      end else if (hit_lo) begin
         rdata_d = cyc_q[31:0];
      end else if (hit_hi) begin
         rdata_d = shadow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q    <= 64'd0;
         shadow_q <= 32'd0;
         rdata_q  <= 32'd0;
      end else begin
         cyc_q <= cyc_q + 64'd1;
         if (rd_req) begin
            rdata_q <= rdata_d;
            // Reading LO snapshots HI so a LO/HI pair is coherent
            if (hit_lo) begin
               shadow_q <= cyc_q[63:32];
            end
         end
      end
   end

   assign dmem_q = rdata_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: expected read data queued at issue, checked by a monitor;
// a UART receiver model checks transmitted bytes against the queue of accepted pushes.
module tb_dmem_mmio_responder;

   localparam int CLK_DIV = 4;
   localparam logic [31:0] UART_DATA = 32'h8000_0000;
   localparam logic [31:0] UART_STAT = 32'h8000_0004;
   localparam logic [31:0] CYC_LO    = 32'h8000_0008;
   localparam logic [31:0] CYC_HI    = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dmem_en = 1'b0;
   logic [31:0] dmem_addr = 32'd0;
   logic [31:0] dmem_d = 32'd0;
   logic [3:0]  dmem_we = 4'd0;
   logic [31:0] dmem_q;
   logic        uart_tx;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   bit          chk_q[$];
   string       name_q[$];
   logic [7:0]  rx_exp_q[$];
   bit          rx_en = 1'b1;
   logic        rd_seen;
   logic [63:0] tb_cyc;

   dmem_mmio_responder #(.RAM_WORDS(1024), .CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dmem_en   (dmem_en),
      .dmem_addr (dmem_addr),
      .dmem_d    (dmem_d),
      .dmem_we   (dmem_we),
      .dmem_q    (dmem_q),
      .uart_tx   (uart_tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Request tracker and reference cycle count
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_seen <= 1'b0;
         tb_cyc  <= 64'd0;
      end else begin
         rd_seen <= dmem_en && (dmem_we == 4'd0);
         tb_cyc  <= tb_cyc + 64'd1;
      end
   end

   // Read-data monitor
   always @(negedge clk) begin
      if (rst_n && rd_seen) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got 0x%08h, expected no response", dmem_q);
         end else begin
            logic [31:0] e;
            bit          c;
            string       n;
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            n = name_q.pop_front();
            if (c) chk(n, dmem_q, e);
         end
      end
   end

   // UART receiver: samples mid-bit
   initial begin : rx
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && rst_n && !uart_tx) begin
            repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               b[k] = uart_tx;
               repeat (CLK_DIV) @(negedge clk);
            end
            chk("rx_stop_bit", 32'(uart_tx), 32'd1);
            if (rx_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected_frame: got 0x%02h, expected no frame", b);
            end else begin
               chk("rx_byte", 32'(b), 32'(rx_exp_q.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      dmem_en   = 1'b1;
      dmem_addr = a;
      dmem_d    = d;
      dmem_we   = we;
      step();
      dmem_en = 1'b0;
      dmem_we = 4'd0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n, input bit c);
      exp_q.push_back(e);
      chk_q.push_back(c);
      name_q.push_back(n);
      dmem_en   = 1'b1;
      dmem_addr = a;
      dmem_we   = 4'd0;
      step();
      dmem_en = 1'b0;
   endtask

   task automatic uart_push(input logic [7:0] b, input bit expect_rx);
      wr(UART_DATA, {24'd0, b}, 4'b0001);
      if (expect_rx) rx_exp_q.push_back(b);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending reads, expected 0", exp_q.size());
      end
   endtask

   task automatic wait_rx_idle();
      for (int i = 0; i < 2000 && rx_exp_q.size() != 0; i++) step();
      if (rx_exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rx_timeout: got %0d bytes outstanding, expected 0", rx_exp_q.size());
      end
      repeat (20) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] v;
      logic       e_bit;
      bit         low_seen;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_dmem_q", dmem_q, 32'd0);
      chk("reset_uart_tx", 32'(uart_tx), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      rd(UART_STAT, 32'h100, "stat_after_reset", 1'b1);
      rd(CYC_HI, 32'd0, "cyc_hi_reset", 1'b1);

      // RAM byte lanes and read-after-write
      wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
      wr(32'h10, 32'h0000_AA00, 4'b0010);
      rd(32'h10, 32'hDEAD_AAEF, "ram_lane1_merge", 1'b1);
      wr(32'h14, 32'h1122_3344, 4'b1111);
      wr(32'h14, 32'hAABB_CCDD, 4'b1001);
      rd(32'h14, 32'hAA22_33DD, "ram_lane0_lane3", 1'b1);
      wr(32'h20, 32'hCAFE_F00D, 4'b1111);
      @(negedge clk);
      chk("dmem_q_hold_on_write", dmem_q, 32'hAA22_33DD);
      step();
      rd(32'h20, 32'hCAFE_F00D, "ram_word2", 1'b1);
      wr(32'h1010, 32'h0BAD_0BAD, 4'b1111);
      rd(32'h10, 32'hDEAD_AAEF, "no_alias_above_ram", 1'b1);
      rd(32'h1010, 32'd0, "unmapped_above_ram", 1'b1);
      rd(32'h4000_0000, 32'd0, "unmapped_read", 1'b1);
      rd(UART_DATA, 32'd0, "uart_data_write_only", 1'b1);

      // Counter ignores writes
      rd(CYC_LO, tb_cyc[31:0], "cyc_lo_live", 1'b1);
      wr(CYC_LO, 32'hFFFF_FFFF, 4'b1111);
      wr(CYC_HI, 32'h1234_5678, 4'b1111);
      rd(CYC_LO, tb_cyc[31:0], "cyc_lo_after_write", 1'b1);
      drain();

      // Single frame: 0x55
      v = 8'h55;
      uart_push(8'h55, 1'b1);
      fork
         begin
            @(negedge clk);
            chk("tx_idle_before_start", 32'(uart_tx), 32'd1);
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (i < 4) e_bit = 1'b0;
               else if (i < 36) e_bit = v[(i - 4) / 4];
               else e_bit = 1'b1;
               chk($sformatf("tx_wave_%0d", i), 32'(uart_tx), 32'(e_bit));
            end
         end
         begin
            repeat (8) step();
            rd(UART_STAT, 32'h500, "stat_busy_mid_frame", 1'b1);
         end
      join
      step();
      repeat (4) step();
      rd(UART_STAT, 32'h100, "stat_idle_after_frame", 1'b1);

      // FIFO fill, overflow and W1C
      wr(UART_DATA, 32'h77, 4'b0010);
      rd(UART_STAT, 32'h100, "no_push_without_we0", 1'b1);
      for (int b = 1; b <= 9; b++) uart_push(8'(b), 1'b1);
      rd(UART_STAT, 32'h608, "stat_full_no_ovf", 1'b1);
      uart_push(8'h0A, 1'b0);
      rd(UART_STAT, 32'hE08, "stat_overflow_set", 1'b1);
      wr(UART_STAT, 32'h800, 4'b0001);
      rd(UART_STAT, 32'hE08, "ovf_clear_needs_we1", 1'b1);
      wr(UART_STAT, 32'h800, 4'b0010);
      rd(UART_STAT, 32'h608, "ovf_cleared", 1'b1);
      wait_rx_idle();
      drain();

      // Shadow of the high word
      force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
      rd(CYC_LO, 32'hFFFF_FFFF, "cyc_lo_forced", 1'b1);
      release dut.cyc_q;
      repeat (3) step();
      rd(CYC_HI, 32'd0, "cyc_hi_shadow_not_live", 1'b1);
      rd(CYC_LO, 32'd0, "cyc_lo_relatch", 1'b0);
      rd(CYC_HI, 32'd1, "cyc_hi_after_wrap", 1'b1);
      drain();

      // Reset in the middle of data bit 3 with 3 bytes queued
      rx_en = 1'b0;
      uart_push(8'h00, 1'b0);
      uart_push(8'h11, 1'b0);
      uart_push(8'h22, 1'b0);
      uart_push(8'h33, 1'b0);
      rd(32'h10, 32'hDEAD_AAEF, "ram_before_reset", 1'b1);
      repeat (14) step();
      chk("tx_data_bit3_low", 32'(uart_tx), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("tx_abort_on_reset", 32'(uart_tx), 32'd1);
      chk("dmem_q_on_reset", dmem_q, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      rd(UART_STAT, 32'h100, "stat_after_midframe_reset", 1'b1);
      rd(CYC_HI, 32'd0, "shadow_after_reset", 1'b1);
      rd(CYC_LO, tb_cyc[31:0], "cyc_lo_after_reset", 1'b1);
      rd(32'h10, 32'hDEAD_AAEF, "ram_kept_over_reset", 1'b1);
      low_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!uart_tx) low_seen = 1'b1;
      end
      chk("fifo_discarded_line_idle", 32'(low_seen), 32'd0);
      step();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
